led_matrix_bcm: RTL
===================

// Module: led_matrix_bcm
// PURPOSE
//  Multi-lane HUB-style LED panel driver using binary-coded modulation (BCM). It reads pixels from a synchronous
//  framebuffer and shifts LANES data lines in parallel on a shared clk_out/latch_out/addr_out bus. Each bit-plane
//  is shown for a time weighted by 2^plane, scaled by a global PWM brightness. The next plane is shifted while the
//  current plane is displayed. Sits between the hdmi_framebuffer read port (through display_mapper) and the panel pins.
// PARAMETERS
//  LANES            2     parallel panel data outputs sharing clk/latch/addr
//  BITS             8     bit-planes per lane (BCM depth); data_in holds BITS bits per lane
//  DISP_ADDR_WIDTH  3     row-select width; ROWS = 2**DISP_ADDR_WIDTH
//  DISPLAY_WIDTH    416   shift clocks per row
//  FB_ADDR_WIDTH    12    data_addr width; must hold ROWS*DISPLAY_WIDTH-1
//  BASE_TICKS       16    clk cycles plane 0 is displayed; plane p = BASE_TICKS<<p
// PORTS
//  clk         in   1                  system clock; all logic on posedge
//  reset       in   1                  asynchronous, active-low reset
//  run         in   1                  1 = scan continuously; 0 = stop at next frame boundary
//  brightness  in   8                  global PWM level, 0 = dark, 255 = full
//  data_addr   out  FB_ADDR_WIDTH      framebuffer read address = row*DISPLAY_WIDTH + x
//  data_in     in   LANES*BITS         lane L pixel at [L*BITS +: BITS]; 1-cycle sync read latency
//  data_out    out  LANES              panel serial data, one bit per lane
//  clk_out     out  1                  panel shift clock; panel samples on rising edge
//  latch_out   out  1                  panel latch strobe, 1 cycle high
//  enable_out  out  1                  panel output enable, active low (1 = blank)
//  addr_out    out  DISP_ADDR_WIDTH    panel row select
//  frame_start out  1                  1-cycle pulse when the shift of row 0 plane 0 begins
// BEHAVIOUR
//  Reset (async, while reset=0): data_out=0, clk_out=0, latch_out=0, enable_out=1, addr_out=0, data_addr=0,
//   frame_start=0. State=IDLE. Shift row sr=0, shift plane sp=0, display timer=0. Reset mid-scan aborts immediately.
//  States: IDLE -> PRIME -> SHIFT_LO <-> SHIFT_HI -> WAIT -> LATCH -> PRIME ... ; DRAIN -> IDLE.
//  IDLE: enable_out=1. When run=1: data_addr<=sr*DISPLAY_WIDTH, go to PRIME.
//  PRIME (2 cycles): holds data_addr so the RAM word is valid. Asserts frame_start in its 1st cycle iff sr=0 and sp=0.
//  SHIFT_LO: clk_out<=0, data_out[L]<=data_in[L*BITS+sp], data_addr<=data_addr+1, x<=x+1.
//  SHIFT_HI: clk_out<=1. After DISPLAY_WIDTH LO/HI pairs (2*DISPLAY_WIDTH cycles) go to WAIT; clk_out stays 1.
//  WAIT: hold until display timer==0, then go to LATCH.
//  LATCH (1 cycle): latch_out=1, enable_out=1, addr_out<=sr, timer<=BASE_TICKS<<sp. Then advance:
//   sp==BITS-1 -> sp=0, sr=sr+1 (wraps to 0 after ROWS-1); else sp=sp+1.
//   If the latched plane was the last of the frame (sr=ROWS-1, sp=BITS-1) and run=0, go to DRAIN; else go to PRIME.
//   data_addr<=new sr*DISPLAY_WIDTH; the same row is re-read for every plane.
//  DRAIN: wait for timer==0, then go to IDLE with enable_out=1. A run 0->1 during DRAIN takes effect from IDLE.
//  Display timer: decrements every cycle while nonzero, in all states, so it overlaps PRIME/SHIFT/WAIT.
//   The first latch after IDLE is therefore immediate once the shift completes.
//  enable_out (registered) = !(timer!=0 && (brightness==8'hFF || pwm<brightness)) outside LATCH/IDLE/reset.
//   pwm is a free-running 8-bit counter. brightness=0 gives permanent blank.
//  brightness and run are sampled every cycle; no other input is registered.
//  Frame period (steady state) = ROWS * sum over p of max(BASE_TICKS<<p, 2*DISPLAY_WIDTH+2) + 1 latch cycle per plane.
// TESTING (bench uses LANES=2, BITS=2, DISPLAY_WIDTH=4, DISP_ADDR_WIDTH=1, BASE_TICKS=4 and a 1-cycle-latency RAM model)
//  1 Reset: drive reset=0 mid-SHIFT between clock edges -> all outputs take their reset values with no clk edge;
//    release reset with run=1 -> frame_start after 1 cycle.
//  2 Data: RAM[x] = {lane1=2'b10, lane0=2'b01} for all x.
//    Plane 0 -> 4 rising clk_out with data_out=2'b01; plane 1 -> 4 rising clk_out with data_out=2'b10.
//  3 Address: data_addr runs 0..4 for both planes of row 0, then 4..8 for row 1.
//    addr_out goes 0 then 1, then wraps to 0. frame_start pulses exactly once per frame.
//  4 Weights: with brightness=255, enable_out is low 4 cycles after the plane-0 latch and 8 cycles after the plane-1 latch.
//    With shift cost 10 > timer, the low time is still exactly 4 and 8 (then blank until the next latch).
//  5 Brightness: brightness=0 -> enable_out never low over 2 frames.
//    brightness=128, BASE_TICKS=256 -> plane-0 low count = 128 +/- 1.
//  6 Stop: drop run mid row 0 -> scan continues through the latch of row 1 plane 1, timer drains,
//    enable_out=1, IDLE with no further latch_out. Reassert run -> next frame restarts at data_addr=0.

Source files
------------

// File: rtl/led_matrix_bcm.sv
// HUB-style LED panel driver using binary-coded modulation.
// Shifts LANES serial lines in parallel from a synchronous framebuffer
// while the previously latched bit-plane is on display; each plane is
// displayed for BASE_TICKS<<plane cycles, gated by a global PWM level.

// Per-lane output bit: captures the current bit-plane of this lane's pixel.
module led_matrix_bcm_lane #(
  parameter int BITS = 8,
  parameter int PW   = 3
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            load,
  input  logic [BITS-1:0] pix,
  input  logic [PW-1:0]   plane,
  output logic            dout
);

  // Register the selected plane bit on each shift-low cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)    dout <= 1'b0;
    else if (load) dout <= pix[plane];
  end

endmodule

module led_matrix_bcm #(
  parameter int LANES           = 2,
  parameter int BITS            = 8,
  parameter int DISP_ADDR_WIDTH = 3,
  parameter int DISPLAY_WIDTH   = 416,
  parameter int FB_ADDR_WIDTH   = 12,
  parameter int BASE_TICKS      = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       run,
  input  logic [7:0]                 brightness,
  output logic [FB_ADDR_WIDTH-1:0]   data_addr,
  input  logic [LANES*BITS-1:0]      data_in,
  output logic [LANES-1:0]           data_out,
  output logic                       clk_out,
  output logic                       latch_out,
  output logic                       enable_out,
  output logic [DISP_ADDR_WIDTH-1:0] addr_out,
  output logic                       frame_start
);

  localparam int ROWS = 2 ** DISP_ADDR_WIDTH;
  localparam int TMAX = BASE_TICKS << (BITS - 1);
  localparam int TW   = $clog2(TMAX + 1);
  localparam int XW   = $clog2(DISPLAY_WIDTH + 1);
  localparam int PW   = (BITS > 1) ? $clog2(BITS) : 1;

  localparam logic [TW-1:0] BASE_T = TW'(BASE_TICKS);

  typedef enum logic [2:0] {
    IDLE, PRIME, SHIFT_LO, SHIFT_HI, WAIT, LATCH, DRAIN
  } state_t;

  state_t                     state;
  logic [DISP_ADDR_WIDTH-1:0] sr, sr_adv;
  logic [PW-1:0]              sp, sp_adv;
  logic [TW-1:0]              timer, timer_nxt;
  logic [XW-1:0]              x;
  logic                       prime_cnt;
  logic [7:0]                 pwm;
  logic                       last_plane, timer_done, bright_ok;

  logic [LANES-1:0][BITS-1:0] pix;
  assign pix = data_in;

  function automatic logic [FB_ADDR_WIDTH-1:0] row_base(input logic [DISP_ADDR_WIDTH-1:0] r);
    return FB_ADDR_WIDTH'(r) * FB_ADDR_WIDTH'(DISPLAY_WIDTH);
  endfunction

  // Next display-timer value: reload on latch, otherwise count down to zero.
  always_comb begin
    timer_nxt = timer;
    if (state == LATCH)   timer_nxt = BASE_T << sp;
    else if (timer != '0) timer_nxt = timer - 1'b1;
  end

  // Plane/row advance and display gating.
  always_comb begin
    last_plane = (sr == DISP_ADDR_WIDTH'(ROWS - 1)) && (sp == PW'(BITS - 1));
    sp_adv     = sp + 1'b1;
    sr_adv     = sr;
    if (sp == PW'(BITS - 1)) begin
      sp_adv = '0;
      sr_adv = sr + 1'b1;
    end
    // Latching in the cycle the timer hits zero keeps the plane period at
    // max(timer, shift) + 1 with no dead WAIT cycle.
    timer_done = (timer_nxt == '0);
    bright_ok  = (brightness == 8'hFF) || (pwm < brightness);
  end

  genvar l;
  for (l = 0; l < LANES; l++) begin : g_lane
    led_matrix_bcm_lane #(.BITS(BITS), .PW(PW)) u_lane (
      .clk   (clk),
      .reset (reset),
      .load  (state == SHIFT_LO),
      .pix   (pix[l]),
      .plane (sp),
      .dout  (data_out[l])
    );
  end

  // Scan FSM with registered panel outputs, display timer and PWM counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      sr          <= '0;
      sp          <= '0;
      timer       <= '0;
      x           <= '0;
      prime_cnt   <= 1'b0;
      pwm         <= '0;
      data_addr   <= '0;
      clk_out     <= 1'b0;
      latch_out   <= 1'b0;
      enable_out  <= 1'b1;
      addr_out    <= '0;
      frame_start <= 1'b0;
    end else begin
      pwm         <= pwm + 1'b1;
      timer       <= timer_nxt;
      latch_out   <= 1'b0;
      frame_start <= 1'b0;
      enable_out  <= !((timer_nxt != '0) && bright_ok);
      case (state)
        IDLE: begin
          enable_out <= 1'b1;
          if (run) begin
            data_addr   <= row_base(sr);
            prime_cnt   <= 1'b0;
            x           <= '0;
            frame_start <= (sr == '0) && (sp == '0);
            state       <= PRIME;
          end
        end
        PRIME: begin
          // Second cycle lets the RAM word for the first pixel arrive.
          if (prime_cnt) state <= SHIFT_LO;
          prime_cnt <= 1'b1;
        end
        SHIFT_LO: begin
          clk_out   <= 1'b0;
          data_addr <= data_addr + 1'b1;
          x         <= x + 1'b1;
          state     <= SHIFT_HI;
        end
        SHIFT_HI: begin
          clk_out <= 1'b1;
          if (x != XW'(DISPLAY_WIDTH)) begin
            state <= SHIFT_LO;
          end else if (timer_done) begin
            state      <= LATCH;
            latch_out  <= 1'b1;
            enable_out <= 1'b1;
            addr_out   <= sr;
          end else begin
            state <= WAIT;
          end
        end
        WAIT: begin
          if (timer_done) begin
            state      <= LATCH;
            latch_out  <= 1'b1;
            enable_out <= 1'b1;
            addr_out   <= sr;
          end
        end
        LATCH: begin
          sp        <= sp_adv;
          sr        <= sr_adv;
          data_addr <= row_base(sr_adv);
          prime_cnt <= 1'b0;
          x         <= '0;
          if (last_plane && !run) begin
            state <= DRAIN;
          end else begin
            frame_start <= last_plane;
            state       <= PRIME;
          end
        end
        DRAIN: begin
          if (timer_done) begin
            state      <= IDLE;
            enable_out <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
